ysyx_23060061_lsu: RTL and testbench
====================================

# ysyx_23060061_lsu

Multi-cycle load/store unit sitting directly downstream of the ALU in the NPC execute path. It takes the effective address produced by the ALU's add operation, plus store data and access size from decode. It then performs one aligned 32-bit memory transaction over a valid/ready request/response port and returns sign- or zero-extended load data, or a store completion, to writeback. Misaligned and illegal accesses are rejected without touching memory.

## Interface
- WIDTH, 32, data/address width; only 32 is supported.
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  execute stage presents an access
- in_ready  out  1  LSU can accept (high only in IDLE)
- in_wen  in  1  1 = store, 0 = load
- in_funct3  in  3  loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores: 000 SB, 001 SH, 010 SW
- in_addr  in  WIDTH  effective address (ALU a+b result)
- in_wdata  in  WIDTH  store data (rs2)
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  WIDTH  word address, in_addr with bits [1:0] forced to 0
- mem_req_wen  out  1  write request
- mem_req_wdata  out  WIDTH  lane-replicated store data
- mem_req_wstrb  out  4  byte write strobes; 0 for loads
- mem_rsp_valid  in  1  memory response (read data or write ack)
- mem_rsp_ready  out  1  LSU accepts response (high only in WAIT)
- mem_rsp_rdata  in  WIDTH  read word
- out_valid  out  1  result available to writeback
- out_ready  in  1  writeback consumes result
- out_rdata  out  WIDTH  extended load data; 0 for stores and errors
- out_err  out  1  access was misaligned or funct3 illegal

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE: in_ready=1. On in_valid, capture all inputs into registers.
  - If the access is illegal, go to RESP with out_err=1.
  - Otherwise go to REQ.
- Illegal accesses:
  - load funct3 011/110/111
  - store funct3 011 or above
  - LH/LHU/SH with addr[0]=1
  - LW/SW with addr[1:0]≠0
- REQ: mem_req_valid=1. All mem_req_* fields are driven from registers and stay stable until mem_req_ready. On mem_req_ready, go to WAIT.
- WAIT: mem_rsp_ready=1. On mem_rsp_valid, register the extracted result and go to RESP. mem_rsp_valid outside WAIT is ignored.
- RESP: out_valid=1; out_rdata/out_err stay stable. On out_ready, go to IDLE.
- Store lanes (a = addr[1:0]):
  - SB: wstrb = 4'b0001<<a, wdata = {4{wdata[7:0]}}
  - SH: wstrb = 4'b0011<<a, wdata = {2{wdata[15:0]}}
  - SW: wstrb = 4'b1111, wdata unchanged
- Load extraction: s = mem_rsp_rdata >> (8*a).
  - LB: sign-extend s[7:0]; LBU: zero-extend s[7:0]
  - LH: sign-extend s[15:0]; LHU: zero-extend s[15:0]
  - LW: s
- Stores also wait for a mem_rsp_valid ack; the response data is discarded and out_rdata=0.
- One access is in flight at a time; no pipelining.

## Timing
- Reset values: state IDLE, in_ready=1. All other outputs 0: mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb, mem_rsp_ready, out_valid, out_rdata, out_err.
- Accept at edge E0 → mem_req_valid high in the cycle after E0.
- With zero-wait memory (req_ready and rsp_valid each high the first cycle they are sampled):
  - request handshake at E1
  - response at E2
  - out_valid high after E2
  - minimum latency is 3 cycles accept→out_valid
- Error path: out_valid high in the cycle after the accept edge; mem_req_valid never asserts.
- Each memory wait cycle (req_ready or rsp_valid low) adds exactly one cycle.
- out_ready held low holds RESP indefinitely. A new in_valid is not accepted until the cycle after the RESP→IDLE transition, so there is no same-cycle turnaround.
- Reset asserted mid-transaction: immediate return to IDLE with reset output values; the outstanding transaction is abandoned. The memory side is reset on the same rst_n.
- mem_req_valid never deasserts before mem_req_ready.

## Test plan
- LW at 0x8000_0004, memory returns 0xDEAD_BEEF with zero wait → req_addr 0x8000_0004, wstrb 0; out_valid 3 cycles after accept; out_rdata 0xDEAD_BEEF, out_err 0.
- LB / LBU at 0x8000_0003, rdata 0x80FF_1234 → LB out_rdata 0xFFFF_FF80; LBU out_rdata 0x0000_0080.
- SH at 0x8000_0002, wdata 0x1234_ABCD → req_addr 0x8000_0000, wstrb 4'b1100, req_wdata 0xABCD_ABCD, wen 1; out_rdata 0 after ack.
- LW at 0x8000_0001 → mem_req_valid never high; out_valid next cycle with out_err 1, out_rdata 0.
- mem_req_ready low 3 cycles, rsp_valid delayed 2 cycles, out_ready delayed 4 cycles → req fields and out fields stable throughout; total accept→out_valid 8 cycles; in_ready low until the cycle after the out handshake.
- rst_n pulsed low while in WAIT → same cycle: state IDLE, in_ready 1, mem_rsp_ready 0, out_valid 0. A following LHU at 0x8000_0002 with rdata 0xF00D_0000 returns 0x0000_F00D.

Source files
------------

// File: rtl/ysyx_23060061_lsu_if.sv
// Bundle of the LSU's execute-side, memory-side and writeback-side handshake signals.
// The master modport is the LSU's view; slave is the view of the surrounding pipeline/memory.
interface ysyx_23060061_lsu_if #(
  parameter int WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic             in_wen;
  logic [2:0]       in_funct3;
  logic [WIDTH-1:0] in_addr;
  logic [WIDTH-1:0] in_wdata;

  logic             mem_req_valid;
  logic             mem_req_ready;
  logic [WIDTH-1:0] mem_req_addr;
  logic             mem_req_wen;
  logic [WIDTH-1:0] mem_req_wdata;
  logic [3:0]       mem_req_wstrb;
  logic             mem_rsp_valid;
  logic             mem_rsp_ready;
  logic [WIDTH-1:0] mem_rsp_rdata;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_rdata;
  logic             out_err;

  modport master (
    input  in_valid, in_wen, in_funct3, in_addr, in_wdata,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata, out_ready,
    output in_ready, mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata,
    output mem_req_wstrb, mem_rsp_ready, out_valid, out_rdata, out_err
  );

  modport slave (
    output in_valid, in_wen, in_funct3, in_addr, in_wdata,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata, out_ready,
    input  in_ready, mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata,
    input  mem_req_wstrb, mem_rsp_ready, out_valid, out_rdata, out_err
  );
endinterface

// File: rtl/ysyx_23060061_lsu.sv
// Multi-cycle load/store unit: one aligned 32-bit memory transaction per access,
// returning extended load data or a store completion; bad accesses never reach memory.
module ysyx_23060061_lsu (
  input logic                  clk,
  input logic                  rst_n,
  ysyx_23060061_lsu_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_e;

  function automatic logic is_illegal(input logic wen, input logic [2:0] f3, input logic [1:0] a);
    logic bad;
    case (f3)
      3'b000:  bad = 1'b0;
      3'b001:  bad = a[0];
      3'b010:  bad = (a != 2'b00);
      3'b100:  bad = wen;
      3'b101:  bad = wen | a[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] lane_strb(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0] strb;
    case (f3[1:0])
      2'b00:   strb = 4'b0001 << a;
      2'b01:   strb = 4'b0011 << a;
      2'b10:   strb = 4'b1111;
      default: strb = 4'b0000;
    endcase
    return strb;
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] wdata);
    logic [31:0] wd;
    case (f3[1:0])
      2'b00:   wd = {4{wdata[7:0]}};
      2'b01:   wd = {2{wdata[15:0]}};
      default: wd = wdata;
    endcase
    return wd;
  endfunction

  function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] a,
                                          input logic [31:0] rdata);
    logic [31:0] s;
    logic [31:0] r;
    s = rdata >> {a, 3'b000};
    case (f3)
      3'b000:  r = {{24{s[7]}}, s[7:0]};
      3'b100:  r = {24'h000000, s[7:0]};
      3'b001:  r = {{16{s[15]}}, s[15:0]};
      3'b101:  r = {16'h0000, s[15:0]};
      default: r = s;
    endcase
    return r;
  endfunction

  state_e      state_q, state_d;
  logic        in_ready_q, in_ready_d;
  logic        mem_req_valid_q, mem_req_valid_d;
  logic [31:0] mem_req_addr_q, mem_req_addr_d;
  logic        mem_req_wen_q, mem_req_wen_d;
  logic [31:0] mem_req_wdata_q, mem_req_wdata_d;
  logic [3:0]  mem_req_wstrb_q, mem_req_wstrb_d;
  logic        mem_rsp_ready_q, mem_rsp_ready_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_rdata_q, out_rdata_d;
  logic        out_err_q, out_err_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  alo_q, alo_d;

  // Next-state and next-output computation for the access FSM.
  always_comb begin
    state_d         = state_q;
    in_ready_d      = in_ready_q;
    mem_req_valid_d = mem_req_valid_q;
    mem_req_addr_d  = mem_req_addr_q;
    mem_req_wen_d   = mem_req_wen_q;
    mem_req_wdata_d = mem_req_wdata_q;
    mem_req_wstrb_d = mem_req_wstrb_q;
    mem_rsp_ready_d = mem_rsp_ready_q;
    out_valid_d     = out_valid_q;
    out_rdata_d     = out_rdata_q;
    out_err_d       = out_err_q;
    funct3_d        = funct3_q;
    alo_d           = alo_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          in_ready_d      = 1'b0;
          funct3_d        = bus.in_funct3;
          alo_d           = bus.in_addr[1:0];
          mem_req_addr_d  = {bus.in_addr[31:2], 2'b00};
          mem_req_wen_d   = bus.in_wen;
          mem_req_wdata_d = lane_wdata(bus.in_funct3, bus.in_wdata);
          mem_req_wstrb_d = bus.in_wen ? lane_strb(bus.in_funct3, bus.in_addr[1:0]) : 4'b0000;
          out_rdata_d     = 32'h0000_0000;
          if (is_illegal(bus.in_wen, bus.in_funct3, bus.in_addr[1:0])) begin
            state_d     = S_RESP;
            out_valid_d = 1'b1;
            out_err_d   = 1'b1;
          end else begin
            state_d         = S_REQ;
            mem_req_valid_d = 1'b1;
            out_err_d       = 1'b0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (bus.mem_req_ready) begin
          state_d         = S_WAIT;
          mem_req_valid_d = 1'b0;
          mem_rsp_ready_d = 1'b1;
        end else begin
          state_d = S_REQ;
        end
      end
      S_WAIT: begin
        if (bus.mem_rsp_valid) begin
          state_d         = S_RESP;
          mem_rsp_ready_d = 1'b0;
          out_valid_d     = 1'b1;
          // Store acks carry no data for writeback.
          out_rdata_d     = mem_req_wen_q ? 32'h0000_0000
                                          : extract(funct3_q, alo_q, bus.mem_rsp_rdata);
        end else begin
          state_d = S_WAIT;
        end
      end
      S_RESP: begin
        if (bus.out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d         = S_IDLE;
        in_ready_d      = 1'b1;
        mem_req_valid_d = 1'b0;
        mem_rsp_ready_d = 1'b0;
        out_valid_d     = 1'b0;
      end
    endcase
  end

  // State and registered-output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      in_ready_q      <= 1'b1;
      mem_req_valid_q <= 1'b0;
      mem_req_addr_q  <= 32'h0000_0000;
      mem_req_wen_q   <= 1'b0;
      mem_req_wdata_q <= 32'h0000_0000;
      mem_req_wstrb_q <= 4'b0000;
      mem_rsp_ready_q <= 1'b0;
      out_valid_q     <= 1'b0;
      out_rdata_q     <= 32'h0000_0000;
      out_err_q       <= 1'b0;
      funct3_q        <= 3'b000;
      alo_q           <= 2'b00;
    end else begin
      state_q         <= state_d;
      in_ready_q      <= in_ready_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_req_addr_q  <= mem_req_addr_d;
      mem_req_wen_q   <= mem_req_wen_d;
      mem_req_wdata_q <= mem_req_wdata_d;
      mem_req_wstrb_q <= mem_req_wstrb_d;
      mem_rsp_ready_q <= mem_rsp_ready_d;
      out_valid_q     <= out_valid_d;
      out_rdata_q     <= out_rdata_d;
      out_err_q       <= out_err_d;
      funct3_q        <= funct3_d;
      alo_q           <= alo_d;
    end
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.mem_req_valid = mem_req_valid_q;
  assign bus.mem_req_addr  = mem_req_addr_q;
  assign bus.mem_req_wen   = mem_req_wen_q;
  assign bus.mem_req_wdata = mem_req_wdata_q;
  assign bus.mem_req_wstrb = mem_req_wstrb_q;
  assign bus.mem_rsp_ready = mem_rsp_ready_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_rdata     = out_rdata_q;
  assign bus.out_err       = out_err_q;

endmodule

// File: tb/tb_ysyx_23060061_lsu.sv
// Directed plus randomized bench for the LSU with an abstract access model and a
// cycle-driven memory responder whose stall lengths are chosen per access.
module tb_ysyx_23060061_lsu;
  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  ysyx_23060061_lsu_if #(.WIDTH(32)) bus ();

  ysyx_23060061_lsu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: what a RISC-V LSU must do for one access, in byte-level terms.
  function automatic void model(input bit wen, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata,
                                output bit err, output logic [31:0] rd,
                                output logic [3:0] strb, output logic [31:0] wd);
    int unsigned size, a;
    logic [31:0] val, mask;
    bit legal_f3;
    legal_f3 = wen ? (f3 inside {3'b000, 3'b001, 3'b010})
                   : (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    size = 1 << f3[1:0];
    a    = addr % 4;
    err  = !legal_f3 || ((addr % size) != 0);
    rd = 32'h0; strb = 4'h0; wd = 32'h0;
    if (!err && wen) begin
      for (int i = 0; i < int'(size); i++) strb[a + i] = 1'b1;
      for (int i = 0; i < 4; i++) wd[8*i +: 8] = wdata[8*(i % size) +: 8];
    end else if (!err) begin
      val = 32'h0;
      for (int i = 0; i < int'(size); i++) val[8*i +: 8] = rdata[8*(a + i) +: 8];
      mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
      if (!f3[2] && size < 4 && val[8*size - 1]) val = val | ~mask;
      rd = val;
    end
  endfunction

  // Run one access from an IDLE negedge through the out handshake.
  task automatic run(input bit wen, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] rdata,
                     input int rq_d, input int rs_d, input int o_d,
                     input bit e_err, input logic [31:0] e_rd,
                     input logic [3:0] e_strb, input logic [31:0] e_wd);
    int edges, k_req, k_rsp;
    bit done;
    chk("in_ready_idle", bus.in_ready, 1);
    bus.in_valid = 1'b1; bus.in_wen = wen; bus.in_funct3 = f3;
    bus.in_addr = addr; bus.in_wdata = wdata;
    @(posedge clk); edges = 1;
    @(negedge clk);
    bus.in_valid = 1'b0; bus.in_wen = 1'($urandom); bus.in_funct3 = 3'($urandom);
    bus.in_addr = $urandom; bus.in_wdata = $urandom;
    k_req = 0; k_rsp = 0; done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (bus.out_valid) begin
        done = 1'b1;
      end else begin
        chk("in_ready_busy", bus.in_ready, 0);
        if (bus.mem_req_valid) begin
          k_req++;
          chk("req_valid_legal", bus.mem_req_valid, !e_err);
          chk("req_addr", bus.mem_req_addr, addr & 32'hFFFF_FFFC);
          chk("req_wen", bus.mem_req_wen, wen);
          chk("req_wstrb", bus.mem_req_wstrb, e_strb);
          if (wen) chk("req_wdata", bus.mem_req_wdata, e_wd);
          bus.mem_req_ready = (k_req > rq_d);
        end else begin
          bus.mem_req_ready = 1'($urandom);
        end
        if (bus.mem_rsp_ready) begin
          k_rsp++;
          bus.mem_rsp_valid = (k_rsp > rs_d);
          bus.mem_rsp_rdata = (k_rsp > rs_d) ? rdata : $urandom;
        end else begin
          bus.mem_rsp_valid = 1'($urandom);
          bus.mem_rsp_rdata = $urandom;
        end
        @(posedge clk); edges++;
        @(negedge clk);
      end
    end
    bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0; bus.mem_rsp_rdata = 32'h0;
    chk("out_valid_timeout", done, 1);
    if (done) begin
      chk("req_seen", (k_req > 0), !e_err);
      chk("latency", edges, e_err ? 1 : 3 + rq_d + rs_d);
      for (int k = 1; k <= o_d + 1; k++) begin
        chk("out_valid", bus.out_valid, 1);
        chk("out_rdata", bus.out_rdata, e_rd);
        chk("out_err", bus.out_err, e_err);
        chk("in_ready_resp", bus.in_ready, 0);
        chk("req_valid_resp", bus.mem_req_valid, 0);
        bus.out_ready = (k > o_d);
        @(posedge clk);
        @(negedge clk);
      end
      bus.out_ready = 1'b0;
      chk("out_valid_after", bus.out_valid, 0);
      chk("in_ready_after", bus.in_ready, 1);
    end
  endtask

  initial begin
    bit e_err;
    logic [31:0] e_rd, e_wd, a, wd, rd;
    logic [3:0] e_strb;
    logic [2:0] f3;
    bit wen;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_wen = 1'b0; bus.in_funct3 = 3'b000;
    bus.in_addr = 32'h0; bus.in_wdata = 32'h0;
    bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0; bus.mem_rsp_rdata = 32'h0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_req_valid", bus.mem_req_valid, 0);
    chk("rst_req_addr", bus.mem_req_addr, 0);
    chk("rst_req_wen", bus.mem_req_wen, 0);
    chk("rst_req_wdata", bus.mem_req_wdata, 0);
    chk("rst_req_wstrb", bus.mem_req_wstrb, 0);
    chk("rst_rsp_ready", bus.mem_rsp_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_rdata", bus.out_rdata, 0);
    chk("rst_out_err", bus.out_err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run(1'b0, 3'b010, 32'h8000_0004, 32'h0, 32'hDEAD_BEEF, 0, 0, 0, 1'b0, 32'hDEAD_BEEF, 4'b0000, 32'h0);
    run(1'b0, 3'b000, 32'h8000_0003, 32'h0, 32'h80FF_1234, 0, 0, 0, 1'b0, 32'hFFFF_FF80, 4'b0000, 32'h0);
    run(1'b0, 3'b100, 32'h8000_0003, 32'h0, 32'h80FF_1234, 0, 0, 0, 1'b0, 32'h0000_0080, 4'b0000, 32'h0);
    run(1'b1, 3'b001, 32'h8000_0002, 32'h1234_ABCD, 32'h5555_5555, 0, 0, 0, 1'b0, 32'h0, 4'b1100, 32'hABCD_ABCD);
    run(1'b0, 3'b010, 32'h8000_0001, 32'h0, 32'h1111_1111, 0, 0, 0, 1'b1, 32'h0, 4'b0000, 32'h0);
    run(1'b1, 3'b000, 32'h8000_0011, 32'h0000_00A5, 32'h0, 1, 1, 1, 1'b0, 32'h0, 4'b0010, 32'hA5A5_A5A5);
    run(1'b0, 3'b001, 32'h8000_0006, 32'h0, 32'h8001_0000, 3, 2, 4, 1'b0, 32'hFFFF_8001, 4'b0000, 32'h0);

    // Reset while the response is outstanding.
    bus.in_valid = 1'b1; bus.in_wen = 1'b0; bus.in_funct3 = 3'b010;
    bus.in_addr = 32'h8000_0008; bus.in_wdata = 32'h0;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0; bus.mem_req_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    chk("wait_rsp_ready", bus.mem_rsp_ready, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", bus.in_ready, 1);
    chk("mid_rst_rsp_ready", bus.mem_rsp_ready, 0);
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_req_valid", bus.mem_req_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run(1'b0, 3'b101, 32'h8000_0002, 32'h0, 32'hF00D_0000, 0, 0, 0, 1'b0, 32'h0000_F00D, 4'b0000, 32'h0);

    for (int n = 0; n < 40; n++) begin
      wen = 1'($urandom);
      f3  = 3'($urandom_range(0, 7));
      a   = 32'h8000_0000 | ($urandom & 32'h0000_00FF);
      wd  = $urandom;
      rd  = $urandom;
      model(wen, f3, a, wd, rd, e_err, e_rd, e_strb, e_wd);
      run(wen, f3, a, wd, rd, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
          e_err, e_rd, e_strb, e_wd);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
